prog_run_ctrl: RTL and testbench

//  Program run controller between the bench req/done handshake and the fetch unit (PC).

---
 rtl/prog_run_ctrl.sv | 113 +++++++++++
 tb/tb_prog_run_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prog_run_ctrl.sv
// Program run controller: selects one of NPROG programs, loads its start PC, runs to halt/end/watchdog, then
// acknowledges over a four-phase req/done handshake. Optional single-step operation under STEP_MODE_EN.
module prog_run_ctrl #(
    parameter int                 D          = 12,
    parameter int                 NPROG      = 4,
    parameter int                 PSW        = 2,
    parameter logic [NPROG*D-1:0] START_ADDR = {12'h180, 12'h100, 12'h080, 12'h000},
    parameter logic [NPROG*D-1:0] END_ADDR   = {12'h200, 12'h180, 12'h100, 12'h080},
    parameter int                 CW         = 16,
    parameter int                 TMO        = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [PSW-1:0] prog_sel,
    input  logic [D-1:0]  pc_now,
    input  logic          halt_instr,
`ifdef STEP_MODE_EN
    input  logic          step,
`endif
    output logic          pc_load,
    output logic [D-1:0]  pc_load_val,
    output logic          pc_hold,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    state_t         state, state_nxt;
    logic [PSW-1:0] sel;
    logic [D-1:0]   start_a, end_a;
    logic           adv, hit_halt, hit_end, hit_tmo, run_exit;

`ifdef STEP_MODE_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    assign start_a = START_ADDR[int'(sel)*D +: D];
    assign end_a   = END_ADDR[int'(sel)*D +: D];

    // Halt is honoured on any RUN cycle; end-address and watchdog only on advancing cycles.
    assign hit_halt = halt_instr;
    assign hit_end  = adv && (pc_now == end_a);
    assign hit_tmo  = adv && (cycle_cnt == TMO_LAST);
    assign run_exit = (state == RUN) && (hit_halt || hit_end || hit_tmo);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (run_exit) state_nxt = DONE;
            DONE:    if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_load     = 1'b0;
        pc_load_val = '0;
        pc_hold     = 1'b1;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            LOAD: begin
                pc_load     = 1'b1;
                pc_load_val = start_a;
                busy        = 1'b1;
            end
            RUN: begin
                busy    = 1'b1;
                // Freeze the PC on the exit cycle so it reports where the run stopped.
                pc_hold = !adv || run_exit;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel       <= '0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) sel <= (int'(prog_sel) < NPROG) ? prog_sel : '0;
                LOAD: begin
                    cycle_cnt <= '0;
                    timeout   <= 1'b0;
                end
                RUN: begin
                    if (adv && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
                    if (run_exit) timeout <= !hit_halt && !hit_end && hit_tmo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: 3-program build, watchdog of 200 RUN cycles, free-running PC model.
// With STEP_MODE_EN defined, step is held high except in the single-step section.
module tb_prog_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  prog_sel = '0;
    logic [11:0] pc = '0;
    logic        halt_instr;
    logic        step = 1'b1;
    logic        pc_load, pc_hold, busy, done, timeout;
    logic [11:0] pc_load_val;
    logic [15:0] cycle_cnt;

    logic        pc_freeze = 1'b0;
    logic        halt_en = 1'b0;
    logic        halt_force = 1'b0;
    logic [11:0] halt_pc = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_run_ctrl #(
        .D(12), .NPROG(3), .PSW(2),
        .START_ADDR({12'h100, 12'h080, 12'h000}),
        .END_ADDR  ({12'h180, 12'h100, 12'h080}),
        .CW(16), .TMO(200)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .pc_now(pc),
        .halt_instr(halt_instr),
`ifdef STEP_MODE_EN
        .step(step),
`endif
        .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_hold(pc_hold), .busy(busy),
        .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt)
    );

    // PC model: load has priority over hold.
    always @(posedge clk) begin
        if (pc_load) pc <= pc_load_val;
        else if (!pc_hold && !pc_freeze) pc <= pc + 12'd1;
    end

    assign halt_instr = halt_force || (halt_en && pc == halt_pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !done; i++) tick();
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hold", {31'd0, pc_hold}, 32'd1);
        chk("rst_load", {31'd0, pc_load}, 32'd0);
        chk("rst_val", {20'd0, pc_load_val}, 32'd0);
        chk("rst_tmo", {31'd0, timeout}, 32'd0);
        chk("rst_cnt", {16'd0, cycle_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Program 0 free-runs 0x000..0x07F; the exit cycle at PC=0x080 is also counted.
        req = 1'b1; prog_sel = 2'd0;
        tick();
        chk("a_load", {31'd0, pc_load}, 32'd1);
        chk("a_val", {20'd0, pc_load_val}, 32'h000);
        chk("a_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("a_run_hold", {31'd0, pc_hold}, 32'd0);
        chk("a_run_cnt", {16'd0, cycle_cnt}, 32'd0);
        wait_done("a_done", 300);
        chk("a_cnt", {16'd0, cycle_cnt}, 32'd129);
        chk("a_tmo", {31'd0, timeout}, 32'd0);
        chk("a_pc", {20'd0, pc}, 32'h080);

        // req held high through DONE never restarts
        repeat (20) tick();
        chk("h_done", {31'd0, done}, 32'd1);
        chk("h_busy", {31'd0, busy}, 32'd0);
        chk("h_cnt", {16'd0, cycle_cnt}, 32'd129);
        chk("h_pc", {20'd0, pc}, 32'h080);
        req = 1'b0;
        tick();
        chk("h_drop", {31'd0, done}, 32'd0);

        // Program 2, halt on 5th RUN cycle (PC 0x104); req dropped early
        req = 1'b1; prog_sel = 2'd2; halt_en = 1'b1; halt_pc = 12'h104;
        tick();
        chk("b_load", {31'd0, pc_load}, 32'd1);
        chk("b_val", {20'd0, pc_load_val}, 32'h100);
        req = 1'b0;
        tick();
        wait_done("b_done", 50);
        chk("b_cnt", {16'd0, cycle_cnt}, 32'd5);
        chk("b_tmo", {31'd0, timeout}, 32'd0);
        chk("b_pc", {20'd0, pc}, 32'h104);
        repeat (3) tick();
        chk("b_pc_frozen", {20'd0, pc}, 32'h104);
        chk("b_idle", {31'd0, done}, 32'd0);
        halt_en = 1'b0;

        // Watchdog: PC stuck at 0x080, never reaching 0x100
        pc_freeze = 1'b1; req = 1'b1; prog_sel = 2'd1;
        tick();
        chk("c_val", {20'd0, pc_load_val}, 32'h080);
        tick();
        wait_done("c_done", 300);
        chk("c_tmo", {31'd0, timeout}, 32'd1);
        chk("c_cnt", {16'd0, cycle_cnt}, 32'd200);
        req = 1'b0;
        tick();
        chk("c_idle", {31'd0, done}, 32'd0);

        // Halt on the watchdog cycle wins: timeout stays 0
        req = 1'b1;
        tick();
        tick();
        repeat (199) tick();
        chk("d_pre_done", {31'd0, done}, 32'd0);
        chk("d_pre_cnt", {16'd0, cycle_cnt}, 32'd199);
        halt_force = 1'b1;
        tick();
        halt_force = 1'b0;
        chk("d_done", {31'd0, done}, 32'd1);
        chk("d_tmo", {31'd0, timeout}, 32'd0);
        chk("d_cnt", {16'd0, cycle_cnt}, 32'd200);
        req = 1'b0; pc_freeze = 1'b0;
        tick();

        // Out-of-range prog_sel clamps to program 0
        req = 1'b1; prog_sel = 2'd3;
        tick();
        chk("e_load", {31'd0, pc_load}, 32'd1);
        chk("e_val", {20'd0, pc_load_val}, 32'h000);
        req = 1'b0;
`ifdef STEP_MODE_EN
        step = 1'b0;
        tick();
        chk("e_step_hold", {31'd0, pc_hold}, 32'd1);
        repeat (3) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (2) tick();
        end
`else
        tick();
        repeat (3) tick();
`endif
        chk("e_cnt", {16'd0, cycle_cnt}, 32'd3);
        chk("e_pc", {20'd0, pc}, 32'h003);
        chk("e_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; step = 1'b1;
        tick();

        // Asynchronous reset mid-RUN on program 1
        req = 1'b1; prog_sel = 2'd1;
        tick();
        req = 1'b0;
        tick();
        repeat (10) tick();
        chk("f_running", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("f_busy", {31'd0, busy}, 32'd0);
        chk("f_done", {31'd0, done}, 32'd0);
        chk("f_hold", {31'd0, pc_hold}, 32'd1);
        chk("f_cnt", {16'd0, cycle_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("f_idle_busy", {31'd0, busy}, 32'd0);
        chk("f_idle_load", {31'd0, pc_load}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
